// File: rtl/smem_writeback_packer.sv
// Packs 256-bit SMEM/end-of-read records in pairs into 512-bit lines behind a FWFT line FIFO.
// Optional feature: define SMEM_WB_COUNT_EN to count accepted SMEM results on smem_count.
module smem_writeback_packer #(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [8:0]   batch_size,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_end,
    input  logic [8:0]   in_read_num,
    input  logic [63:0]  in_x0,
    input  logic [63:0]  in_x1,
    input  logic [63:0]  in_x2,
    input  logic [31:0]  in_info,
    output logic         out_valid,
    output logic [511:0] out_data,
    input  logic         out_ready,
    output logic         batch_done,
    output logic [31:0]  smem_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [255:0] PAD_RECORD = {1'b0, 1'b1, 254'd0};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [255:0] make_record(
        input logic        is_end,
        input logic [8:0]  read_num,
        input logic [63:0] x0,
        input logic [63:0] x1,
        input logic [63:0] x2,
        input logic [31:0] info
    );
        logic [255:0] rec;
        rec = 256'd0;
        rec[232:224] = read_num;
        if (is_end) begin
            // End markers ignore the interval inputs entirely.
            rec[255] = 1'b1;
        end else begin
            rec[63:0]    = x0;
            rec[127:64]  = x1;
            rec[191:128] = x2;
            rec[223:192] = info;
        end
        return rec;
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [255:0]       slot_r;
    logic               slot_full_r;
    logic               flush_pending_r;
    logic [8:0]         end_cnt_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [511:0]       mem_r [DEPTH];

    logic               accept_s;
    logic [255:0]       record_s;
    logic               last_end_s;
    logic               flush_go_s;
    logic               drained_s;
    logic               push_s;
    logic [511:0]       push_line_s;
    logic               pop_s;

    assign batch_done = (state_r == ST_DONE);
    assign in_ready   = reset_n && !batch_done && !flush_pending_r && (count_r < DEPTH_C);
    assign out_valid  = reset_n && (count_r != {CNT_W{1'b0}});
    assign out_data   = out_valid ? mem_r[rd_ptr_r] : 512'd0;

    // Handshake decode and line assembly.
    always_comb begin
        accept_s    = in_valid && in_ready;
        record_s    = make_record(in_end, in_read_num, in_x0, in_x1, in_x2, in_info);
        last_end_s  = accept_s && in_end && (batch_size != 9'd0) &&
                      ((end_cnt_r + 9'd1) == batch_size);
        flush_go_s  = flush_pending_r && (count_r < DEPTH_C);
        drained_s   = (batch_size != 9'd0) && (end_cnt_r == batch_size) &&
                      !flush_pending_r && !slot_full_r && (count_r == {CNT_W{1'b0}});
        pop_s       = out_valid && out_ready;
        push_s      = 1'b0;
        push_line_s = 512'd0;
        if (accept_s && slot_full_r) begin
            push_s      = 1'b1;
            push_line_s = {record_s, slot_r};
        end else if (flush_go_s && slot_full_r) begin
            push_s      = 1'b1;
            push_line_s = {PAD_RECORD, slot_r};
        end else begin
            push_s      = 1'b0;
            push_line_s = 512'd0;
        end
    end

    // Batch state next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (last_end_s) begin
                    state_nxt_s = ST_FLUSH;
                end else if (accept_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_end_s) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (drained_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_DONE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Batch state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Packing slot, end-of-read counter and flush request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_r          <= 256'd0;
            slot_full_r     <= 1'b0;
            flush_pending_r <= 1'b0;
            end_cnt_r       <= 9'd0;
        end else begin
            if (accept_s) begin
                if (slot_full_r) begin
                    slot_full_r <= 1'b0;
                end else begin
                    slot_r      <= record_s;
                    slot_full_r <= 1'b1;
                end
                if (in_end) begin
                    end_cnt_r <= end_cnt_r + 9'd1;
                end
                if (last_end_s) begin
                    flush_pending_r <= 1'b1;
                end
            end else if (flush_go_s) begin
                slot_full_r     <= 1'b0;
                flush_pending_r <= 1'b0;
            end
        end
    end

    // Line FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Line storage; contents are don't-care once the pointers reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_line_s;
        end
    end

`ifdef SMEM_WB_COUNT_EN
    logic [31:0] smem_count_r;

    // Accepted SMEM result counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            smem_count_r <= 32'd0;
        end else if (accept_s && !in_end) begin
            smem_count_r <= smem_count_r + 32'd1;
        end
    end

    assign smem_count = smem_count_r;
`else
    assign smem_count = 32'd0;
`endif

endmodule

// File: tb/tb_smem_writeback_packer.sv
// Randomized self-checking bench for smem_writeback_packer against a queue-based line model.
module tb_smem_writeback_packer;

    localparam int DEPTH = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [8:0]   batch_size = 9'd0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_end = 1'b0;
    logic [8:0]   in_read_num = 9'd0;
    logic [63:0]  in_x0 = 64'd0;
    logic [63:0]  in_x1 = 64'd0;
    logic [63:0]  in_x2 = 64'd0;
    logic [31:0]  in_info = 32'd0;
    logic         out_valid;
    logic [511:0] out_data;
    logic         out_ready = 1'b0;
    logic         batch_done;
    logic [31:0]  smem_count;

    smem_writeback_packer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .batch_size(batch_size),
        .in_valid(in_valid), .in_ready(in_ready), .in_end(in_end),
        .in_read_num(in_read_num), .in_x0(in_x0), .in_x1(in_x1), .in_x2(in_x2),
        .in_info(in_info), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .batch_done(batch_done), .smem_count(smem_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: FIFO contents as a queue of whole lines.
    logic [511:0] m_q[$];
    logic [255:0] m_slot = 256'd0;
    bit           m_slot_full = 1'b0;
    bit           m_flush = 1'b0;
    bit           m_done = 1'b0;
    logic [8:0]   m_ends = 9'd0;
    logic [31:0]  m_smem = 32'd0;
    bit           acc_last = 1'b0;
    int           or_mode = 0;
    int           dut_pops = 0;
    logic [511:0] last_pop = 512'd0;

    task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_rec(input logic e, input logic [8:0] rn, input logic [63:0] a,
                                             input logic [63:0] b, input logic [63:0] c, input logic [31:0] inf);
        logic [255:0] r;
        r = 256'd0;
        r[232:224] = rn;
        if (e) r[255] = 1'b1;
        else begin
            r[63:0] = a; r[127:64] = b; r[191:128] = c; r[223:192] = inf;
        end
        return r;
    endfunction

    function automatic bit m_ready();
        return reset_n && !m_done && !m_flush && (m_q.size() < DEPTH);
    endfunction

    task automatic model_edge();
        int           cnt0;
        bit           acc;
        bit           done_n;
        logic [255:0] rec;
        if (!reset_n) begin
            m_q.delete();
            m_slot_full = 1'b0; m_flush = 1'b0; m_done = 1'b0;
            m_ends = 9'd0; m_smem = 32'd0; acc_last = 1'b0;
        end else begin
            cnt0   = m_q.size();
            acc    = in_valid && m_ready();
            done_n = (batch_size != 9'd0) && (m_ends == batch_size) && !m_flush && !m_slot_full && (cnt0 == 0);
            if (cnt0 != 0 && out_ready) void'(m_q.pop_front());
            if (acc) begin
                rec = mk_rec(in_end, in_read_num, in_x0, in_x1, in_x2, in_info);
                if (m_slot_full) begin
                    m_q.push_back({rec, m_slot});
                    m_slot_full = 1'b0;
                end else begin
                    m_slot = rec;
                    m_slot_full = 1'b1;
                end
                if (in_end) begin
                    m_ends = m_ends + 9'd1;
                    if (batch_size != 9'd0 && m_ends == batch_size) m_flush = 1'b1;
                end else begin
`ifdef SMEM_WB_COUNT_EN
                    m_smem = m_smem + 32'd1;
`endif
                end
            end else if (m_flush && cnt0 < DEPTH) begin
                if (m_slot_full) m_q.push_back({1'b0, 1'b1, 254'd0, m_slot});
                m_slot_full = 1'b0;
                m_flush = 1'b0;
            end
            if (done_n) m_done = 1'b1;
            acc_last = acc;
        end
    endtask

    // One clock: compare outputs mid-cycle, then advance DUT and model together.
    task automatic step();
        bit exp_v;
        case (or_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            2: out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        exp_v = reset_n && (m_q.size() != 0);
        check_eq("in_ready", {511'd0, in_ready}, {511'd0, m_ready()});
        check_eq("out_valid", {511'd0, out_valid}, {511'd0, exp_v});
        check_eq("out_data", out_data, exp_v ? m_q[0] : 512'd0);
        check_eq("batch_done", {511'd0, batch_done}, {511'd0, m_done});
        check_eq("smem_count", {480'd0, smem_count}, {480'd0, m_smem});
        if (out_valid && out_ready) begin
            dut_pops++;
            last_pop = out_data;
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send(input logic e, input logic [8:0] rn, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] c, input logic [31:0] inf);
        bit ok;
        ok = 1'b0;
        in_end = e; in_read_num = rn; in_x0 = a; in_x1 = b; in_x2 = c; in_info = inf;
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            step();
            if (acc_last) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: record not accepted within 200 cycles");
        end
    endtask

    task automatic send_rand(input logic e, input logic [8:0] rn);
        send(e, rn, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, $urandom);
    endtask

    task automatic do_reset(input logic [8:0] bs);
        reset_n = 1'b0; in_valid = 1'b0; batch_size = bs;
        step(); step();
        reset_n = 1'b1;
        dut_pops = 0;
    endtask

    task automatic wait_done(input int budget);
        for (int n = 0; n < budget && !m_done; n++) step();
        repeat (3) step();
        check_eq("batch_done_final", {511'd0, batch_done}, {511'd0, 1'b1});
    endtask

    logic [511:0] exp_line;
    int           nrec;

    initial begin
        repeat (2) @(posedge clk);
        #1;

        // Single SMEM plus its end marker.
        or_mode = 0;
        do_reset(9'd1);
        send(1'b0, 9'd0, 64'h11, 64'd0, 64'd0, 32'd0);
        send(1'b1, 9'd0, 64'hdead, 64'hbeef, 64'hcafe, 32'h1234);
        exp_line = 512'd0;
        exp_line[63:0] = 64'h11;
        exp_line[511] = 1'b1;
        check_eq("t1_line", out_data, exp_line);
        wait_done(50);
        check_eq("t1_pops", dut_pops, 1);

        // Odd record count closes with a pad record.
        do_reset(9'd2);
        send_rand(1'b0, 9'd0);
        send_rand(1'b1, 9'd0);
        send_rand(1'b1, 9'd1);
        wait_done(50);
        check_eq("t2_pops", dut_pops, 2);
        exp_line = 512'd0;
        exp_line[510] = 1'b1;
        exp_line[255] = 1'b1;
        exp_line[232:224] = 9'd1;
        check_eq("t2_pad_line", last_pop, exp_line);

        // Back-pressure fills the FIFO, then drains in order.
        do_reset(9'd3);
        or_mode = 1;
        for (int i = 0; i < 2 * DEPTH; i++) send_rand(1'b0, 9'(i));
        check_eq("t3_full_ready", {511'd0, in_ready}, 512'd0);
        or_mode = 0;
        repeat (12) step();
        check_eq("t3_pops", dut_pops, DEPTH);

        // Reset mid-batch with a partial slot and queued lines.
        do_reset(9'd5);
        or_mode = 1;
        for (int i = 0; i < 7; i++) send_rand(1'b0, 9'(i));
        do_reset(9'd1);
        check_eq("t4_out_valid", {511'd0, out_valid}, 512'd0);
        check_eq("t4_batch_done", {511'd0, batch_done}, 512'd0);
        or_mode = 0;
        send_rand(1'b0, 9'd7);
        send_rand(1'b1, 9'd7);
        wait_done(50);
        check_eq("t4_pops", dut_pops, 1);

        // Toggling out_ready under continuous input.
        do_reset(9'd1);
        or_mode = 2;
        for (int i = 0; i < 64; i++) send_rand(1'b0, 9'd0);
`ifdef SMEM_WB_COUNT_EN
        check_eq("t5_smem_count", {480'd0, smem_count}, {480'd0, 32'd64});
`else
        check_eq("t5_smem_count", {480'd0, smem_count}, 512'd0);
`endif
        send_rand(1'b1, 9'd0);
        wait_done(200);
        check_eq("t5_pops", dut_pops, 33);

        // Zero batch size never completes.
        do_reset(9'd0);
        or_mode = 3;
        send_rand(1'b0, 9'd0);
        send_rand(1'b1, 9'd0);
        send_rand(1'b0, 9'd1);
        send_rand(1'b1, 9'd1);
        send_rand(1'b0, 9'd2);
        repeat (20) step();
        check_eq("t6_no_done", {511'd0, batch_done}, 512'd0);

        // Random batches.
        for (int b = 0; b < 6; b++) begin
            do_reset(9'($urandom_range(1, 6)));
            or_mode = 3;
            for (int r = 0; r < int'(batch_size); r++) begin
                nrec = $urandom_range(0, 3);
                for (int k = 0; k < nrec; k++) send_rand(1'b0, 9'(r));
                send_rand(1'b1, 9'(r));
            end
            wait_done(300);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
